mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 12-bit output path between four class lanes (class ID in bits [11:10]).
- Each lane is fronted by a show-ahead FIFO. The block:
  - issues one-hot pops to those FIFOs;
  - checks that each word's class ID matches its lane;
  - registers the selected word onto data_out.
- Sits between the four lane FIFOs and the downstream output FIFO; honours the output FIFO's almost-full backpressure.

---
 rtl/mux_rr_scheduler_pkg.sv | 28 ++
 rtl/mux_rr_scheduler_rr_pick4.sv | 17 +
 rtl/mux_rr_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the four-lane round-robin output multiplexer:
// lane/class constants, FSM state encoding and the round-robin search helper.
package mux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned CLASS_W   = 2;

  typedef logic [CLASS_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } sched_state_t;

  // First requesting lane at or after start, wrapping; returns start if none.
  // Scanned from the farthest offset down so the nearest requester wins.
  function automatic lane_t next_req(input logic [NUM_LANES-1:0] req,
                                     input lane_t start);
    lane_t idx;
    next_req = start;
    for (int unsigned i = NUM_LANES; i > 0; i--) begin
      idx = lane_t'(start + lane_t'(i - 1));
      if (req[idx]) next_req = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick4.sv
// Combinational four-way round-robin picker: first requester at or after
// rr_ptr, plus a flag saying whether anyone requests at all.
import mux_pkg::*;

module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic [1:0] grant,
  output logic       any
);

  always_comb begin
    grant = next_req(req, rr_ptr);
    any   = |req;
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one output path between four class lanes,
// with per-word class checking. Optional statistics: define MUX_RR_STATS_EN.
import mux_pkg::*;

module mux_rr_scheduler #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  input  logic              out_almost_full,
  output logic [3:0]        fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              class_err
`ifdef MUX_RR_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1,
  output logic [7:0]        grant_cnt2,
  output logic [7:0]        grant_cnt3,
  output logic [7:0]        drop_cnt
`endif
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  sched_state_t      state_q, state_d;
  lane_t             grant_q, grant_d;
  lane_t             rr_ptr_q, rr_ptr_d;
  logic [3:0]        burst_q, burst_d;

  logic [3:0]        req;
  logic              stall;
  logic              others;
  lane_t             after_grant;
  lane_t             arb_lane, rot_lane;
  logic              arb_any, rot_any;

  logic              pop_en;
  lane_t             pop_lane;
  logic [DATA_W-1:0] head [NUM_LANES];
  logic [DATA_W-1:0] pop_word;
  logic              word_ok;

  always_comb begin
    req         = ~fifo_empty;
    stall       = out_almost_full;
    after_grant = lane_t'(grant_q + 2'd1);
    others      = |(req & ~(4'b0001 << grant_q));
  end

  // Fresh arbitration starts from rr_ptr; rotation starts just past the owner.
  rr_pick4 u_pick_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .grant  (arb_lane),
    .any    (arb_any)
  );

  rr_pick4 u_pick_rot (
    .req    (req),
    .rr_ptr (after_grant),
    .grant  (rot_lane),
    .any    (rot_any)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    pop_en   = 1'b0;
    pop_lane = grant_q;

    unique case (state_q)
      IDLE: begin
        if (arb_any && !stall) begin
          pop_en   = 1'b1;
          pop_lane = arb_lane;
          grant_d  = arb_lane;
          burst_d  = 4'd1;
          state_d  = SERVE;
        end
      end

      // A released stall whose owner still requests resumes exactly as SERVE,
      // so the burst count carried through the stall is honoured.
      SERVE, STALL: begin
        if (stall) begin
          state_d = STALL;
        end else if (state_q == STALL && !req[grant_q]) begin
          if (arb_any) begin
            pop_en   = 1'b1;
            pop_lane = arb_lane;
            grant_d  = arb_lane;
            burst_d  = 4'd1;
            state_d  = SERVE;
          end else begin
            state_d  = IDLE;
          end
        end else if (!rot_any) begin
          rr_ptr_d = after_grant;
          state_d  = IDLE;
        end else if (!req[grant_q] || (burst_q == BURST_MAX && others)) begin
          pop_en   = 1'b1;
          pop_lane = rot_lane;
          grant_d  = rot_lane;
          rr_ptr_d = after_grant;
          burst_d  = 4'd1;
          state_d  = SERVE;
        end else begin
          pop_en   = 1'b1;
          pop_lane = grant_q;
          if (burst_q != BURST_MAX) burst_d = burst_q + 4'd1;
          state_d  = SERVE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head[0]  = fifo_data0;
    head[1]  = fifo_data1;
    head[2]  = fifo_data2;
    head[3]  = fifo_data3;
    pop_word = head[pop_lane];
    word_ok  = (pop_word != '0) && (pop_word[DATA_W-1 -: CLASS_W] == pop_lane);
    fifo_pop = (pop_en && reset_L) ? (4'b0001 << pop_lane) : '0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      class_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      valid_out <= pop_en && word_ok;
      if (pop_en && word_ok)  data_out  <= pop_word;
      if (pop_en && !word_ok) class_err <= 1'b1;
    end
  end

`ifdef MUX_RR_STATS_EN
  logic [7:0] gcnt [NUM_LANES];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) gcnt[i] <= '0;
      drop_cnt <= '0;
    end else if (pop_en) begin
      if (word_ok)              gcnt[pop_lane] <= gcnt[pop_lane] + 8'd1;
      else if (drop_cnt != '1)  drop_cnt       <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    grant_cnt0 = gcnt[0];
    grant_cnt1 = gcnt[1];
    grant_cnt2 = gcnt[2];
    grant_cnt3 = gcnt[3];
  end
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: queue-backed lane FIFOs, a
// behavioural round-robin reference, directed scenarios and random traffic.
module tb_mux_rr_scheduler;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [3:0]  fifo_empty;
  logic [11:0] fd [4];
  logic        stall = 1'b0;
  logic [3:0]  fifo_pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic        class_err;
`ifdef MUX_RR_STATS_EN
  logic [7:0]  gc [4];
  logic [7:0]  dc;
`endif

  always #5 clk = ~clk;

  mux_rr_scheduler #(.DATA_W(12), .MAX_BURST(MAXB)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .fifo_empty      (fifo_empty),
    .fifo_data0      (fd[0]),
    .fifo_data1      (fd[1]),
    .fifo_data2      (fd[2]),
    .fifo_data3      (fd[3]),
    .out_almost_full (stall),
    .fifo_pop        (fifo_pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .class_err       (class_err)
`ifdef MUX_RR_STATS_EN
    ,
    .grant_cnt0      (gc[0]),
    .grant_cnt1      (gc[1]),
    .grant_cnt2      (gc[2]),
    .grant_cnt3      (gc[3]),
    .drop_cnt        (dc)
`endif
  );

  // Lane FIFO contents and observed output stream
  logic [11:0] lq [4][$];
  logic [11:0] seen [$];
  int          seen_cyc [$];
  int          pops [$];
  int          cyc = 0;
  int          last_pop;
  logic [3:0]  last_dut_pop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: who owns the output, whether paused by backpressure,
  // where the next fresh search starts, and how long the current run is.
  bit          m_busy, m_paused;
  int          m_owner, m_ptr, m_run;
  logic        m_valid, m_err;
  logic [11:0] m_data;
  int          m_fwd [4];
  int          m_drop;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_paused = 0; m_owner = 0; m_ptr = 0; m_run = 0;
    m_valid = 0; m_err = 0; m_data = '0; m_drop = 0;
    for (int i = 0; i < 4; i++) m_fwd[i] = 0;
  endfunction

  // Which lane the scheduler should pop this cycle (-1: none)
  task automatic decide(input logic [3:0] req, output int lane);
    lane = -1;
    if (!m_busy) begin
      if (req != 0 && !stall) begin
        lane = first_from(req, m_ptr);
        m_owner = lane; m_run = 1; m_busy = 1; m_paused = 0;
      end
    end else if (stall) begin
      m_paused = 1;
    end else if (m_paused && !req[m_owner]) begin
      m_paused = 0;
      if (req != 0) begin
        lane = first_from(req, m_ptr);
        m_owner = lane; m_run = 1;
      end else begin
        m_busy = 0;
      end
    end else begin
      m_paused = 0;
      if (req == 0) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % 4;
      end else if (!req[m_owner] ||
                   (m_run == MAXB && (req & ~(4'b0001 << m_owner)) != 0)) begin
        m_ptr   = (m_owner + 1) % 4;
        lane    = first_from(req, m_ptr);
        m_owner = lane;
        m_run   = 1;
      end else begin
        lane = m_owner;
        if (m_run < MAXB) m_run++;
      end
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (lq[i].size() == 0);
      fd[i]         = (lq[i].size() != 0) ? lq[i][0] : 12'h000;
    end
  endtask

  // One clock: drive, check pop, advance model, check registered outputs
  task automatic cycle(input logic stall_in);
    int          lane;
    logic [3:0]  req, exp_pop;
    logic [11:0] w;
    @(negedge clk);
    stall = stall_in;
    drive_inputs();
    #1;
    req = ~fifo_empty;
    decide(req, lane);
    exp_pop = (lane >= 0) ? (4'b0001 << lane) : 4'b0000;
    check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    last_dut_pop = fifo_pop;
    m_valid = 0;
    if (lane >= 0) begin
      w = lq[lane][0];
      if (w != 12'h000 && w[11:10] == 2'(lane)) begin
        m_valid = 1; m_data = w;
        m_fwd[lane] = (m_fwd[lane] + 1) % 256;
      end else begin
        m_err = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (last_dut_pop[i]) begin
        check("pop_nonempty", 32'(lq[i].size() != 0), 32'd1);
        if (lq[i].size() != 0) void'(lq[i].pop_front());
      end
    #1;
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("data_out",  32'(data_out),  32'(m_data));
    check("class_err", 32'(class_err), 32'(m_err));
    if (valid_out) begin
      seen.push_back(data_out);
      seen_cyc.push_back(cyc);
    end
    pops.push_back(lane);
    last_pop = lane;
    cyc++;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 4; i++) lq[i].delete();
    seen.delete(); seen_cyc.delete(); pops.delete();
  endtask

  // Asynchronous assert between edges, release just after a rising edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    check("rst_fifo_pop",  32'(fifo_pop),  32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out",  32'(data_out),  32'd0);
    check("rst_class_err", 32'(class_err), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset_L = 1'b1;
  endtask

  typedef struct {
    int          lane;
    logic [11:0] word;
    bit          fwd;
  } cls_vec_t;

  cls_vec_t tbl [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          err_acc;
    int          budget;
    int          lane, n;
    logic [11:0] w;
    logic [9:0]  payload;

    tbl[0] = '{3, 12'h000, 1'b0};
    tbl[1] = '{3, 12'h412, 1'b0};
    tbl[2] = '{3, 12'hC05, 1'b1};
    tbl[3] = '{0, 12'h001, 1'b1};
    tbl[4] = '{1, 12'h401, 1'b1};
    tbl[5] = '{2, 12'h800, 1'b1};
    tbl[6] = '{0, 12'h400, 1'b0};
    tbl[7] = '{2, 12'hC00, 1'b0};
    tbl[8] = '{1, 12'h000, 1'b0};

    clear_env();
    drive_inputs();
    model_reset();
    do_reset();

    // All four lanes loaded: bursts of MAX_BURST in lane order, no gaps
    clear_env();
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 16; k++) lq[i].push_back(12'((i << 10) | k));
    budget = 0;
    while (seen.size() < 64 && budget < 120) begin cycle(1'b0); budget++; end
    check("s1_count", 32'(seen.size()), 32'd64);
    for (int k = 0; k < 64 && k < seen.size(); k++)
      check("s1_order", 32'(seen[k]),
            32'((((k / 4) % 4) << 10) | ((k / 16) * 4 + (k % 4) + 1)));
    if (seen.size() == 64) check("s1_continuous", 32'(seen_cyc[63] - seen_cyc[0]), 32'd63);
`ifdef MUX_RR_STATS_EN
    for (int i = 0; i < 4; i++) check("s1_grant_cnt", 32'(gc[i]), 32'd16);
    check("s1_drop_cnt", 32'(dc), 32'd0);
`endif

    // Single active lane keeps the grant beyond MAX_BURST
    do_reset();
    clear_env();
    for (int k = 1; k <= 10; k++) lq[2].push_back(12'h800 | 12'(k));
    for (int c = 0; c < 14; c++) cycle(1'b0);
    check("s2_count", 32'(seen.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      check("s2_pop_lane", 32'(pops[k]), 32'd2);
      if (k < seen.size()) check("s2_data", 32'(seen[k]), 32'(12'h800 | 12'(k + 1)));
    end

    // Backpressure mid-burst on lane 1 after two words
    do_reset();
    clear_env();
    for (int k = 1; k <= 6; k++) begin
      lq[1].push_back(12'h400 | 12'(k));
      lq[2].push_back(12'h800 | 12'(k));
    end
    cycle(1'b0); cycle(1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b1);
      check("s3_stall_pop",   32'(last_dut_pop), 32'd0);
      check("s3_stall_valid", 32'(valid_out),    32'd0);
    end
    for (int c = 0; c < 3; c++) cycle(1'b0);
    check("s3_resume_a", 32'(pops[5]), 32'd1);
    check("s3_resume_b", 32'(pops[6]), 32'd1);
    check("s3_rotate",   32'(pops[7]), 32'd2);

    // Class check vectors, in order; class_err is sticky
    do_reset();
    clear_env();
    err_acc = 0;
    foreach (tbl[t]) begin
      lq[tbl[t].lane].push_back(tbl[t].word);
      budget = 0;
      do begin cycle(1'b0); budget++; end while (last_pop != tbl[t].lane && budget < 4);
      check("cls_popped", 32'(last_pop), 32'(tbl[t].lane));
      err_acc = err_acc | !tbl[t].fwd;
      check("cls_valid", 32'(valid_out), 32'(tbl[t].fwd));
      check("cls_err",   32'(class_err), 32'(err_acc));
      if (tbl[t].fwd) check("cls_data", 32'(data_out), 32'(tbl[t].word));
    end

    // Reset during a lane-2 burst restarts arbitration from lane 0
    do_reset();
    clear_env();
    for (int k = 1; k <= 8; k++) lq[2].push_back(12'h800 | 12'(k));
    cycle(1'b0); cycle(1'b0);
    for (int k = 1; k <= 4; k++) lq[1].push_back(12'h400 | 12'(k));
    cycle(1'b0);
    check("s5_pre_lane", 32'(last_pop), 32'd2);
    do_reset();
    cycle(1'b0);
    check("s5_first_grant", 32'(last_pop), 32'd1);

    // Random traffic against the reference model
    do_reset();
    clear_env();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 9) < 4) begin
        lane = int'($urandom_range(0, 3));
        n    = int'($urandom_range(1, 3));
        for (int k = 0; k < n && lq[lane].size() < 8; k++) begin
          payload = 10'($urandom);
          if ($urandom_range(0, 9) == 0) w = 12'($urandom);
          else w = {2'(lane), payload};
          lq[lane].push_back(w);
        end
      end
      cycle($urandom_range(0, 9) < 2);
    end
`ifdef MUX_RR_STATS_EN
    for (int i = 0; i < 4; i++) check("rnd_grant_cnt", 32'(gc[i]), 32'(m_fwd[i]));
    check("rnd_drop_cnt", 32'(dc), 32'(m_drop));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
